// File: rtl/snake_color_ctrl.sv
// Game-phase sequencer for the snake colour selector: IDLE/PLAY/OVER phases,
// eat-flash and game-over border blink, all timed in frames.
//   state   | meaning
//   ST_IDLE | attract screen, border only, waiting for start
//   ST_PLAY | game running, snake may flash after eating
//   ST_OVER | game halted, border blinks until the hold time expires
module snake_color_ctrl #(
  parameter logic [2:0] BORDER_COLOR      = 3'b111,
  parameter logic [2:0] APPLE_COLOR       = 3'b100,
  parameter logic [2:0] SNAKE_COLOR       = 3'b010,
  parameter logic [2:0] FLASH_COLOR       = 3'b110,
  parameter logic [2:0] OVER_COLOR        = 3'b100,
  parameter int         EAT_FLASH_FRAMES  = 8,
  parameter int         OVER_BLINK_FRAMES = 16,
  parameter int         OVER_HOLD_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       apple_eaten,
  input  logic       collision,
  output logic [2:0] rgb_border,
  output logic [2:0] rgb_apple,
  output logic [2:0] rgb_snake,
  output logic       display_blank,
  output logic       game_run,
  output logic [1:0] phase
);

  localparam int FLW = $clog2(EAT_FLASH_FRAMES + 1);
  localparam int FRW = $clog2(OVER_HOLD_FRAMES + 1);
  localparam int BLW = $clog2(OVER_BLINK_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [FLW-1:0] flash_cnt_q, flash_cnt_d;
  logic [FRW-1:0] frame_cnt_q, frame_cnt_d;
  logic [BLW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_on_q, blink_on_d;
  logic           blank_q, blank_d;
  logic [2:0]     rgb_border_q, rgb_border_d;
  logic [2:0]     rgb_apple_q, rgb_apple_d;
  logic [2:0]     rgb_snake_q, rgb_snake_d;
  logic           run_q, run_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      flash_cnt_q  <= '0;
      frame_cnt_q  <= '0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b0;
      blank_q      <= 1'b1;
      rgb_border_q <= BORDER_COLOR;
      rgb_apple_q  <= 3'b000;
      rgb_snake_q  <= 3'b000;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      flash_cnt_q  <= flash_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      blank_q      <= blank_d;
      rgb_border_q <= rgb_border_d;
      rgb_apple_q  <= rgb_apple_d;
      rgb_snake_q  <= rgb_snake_d;
      run_q        <= run_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flash_cnt_d = flash_cnt_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    blank_d     = blank_q;
    case (state_q)
      ST_IDLE: begin
        flash_cnt_d = '0;
        frame_cnt_d = '0;
        blank_d     = 1'b0;
        if (start) begin
          state_d = ST_PLAY;
          blank_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (collision) begin
          state_d     = ST_OVER;
          flash_cnt_d = '0;
          frame_cnt_d = '0;
          blink_cnt_d = BLW'(OVER_BLINK_FRAMES - 1);
          blink_on_d  = 1'b1;
          blank_d     = 1'b0;
        end else begin
          blank_d = blank_q & ~frame_tick;
          // A fresh apple reloads the flash even on a frame tick.
          if (apple_eaten) begin
            flash_cnt_d = FLW'(EAT_FLASH_FRAMES);
          end else if (frame_tick && (flash_cnt_q != '0)) begin
            flash_cnt_d = flash_cnt_q - FLW'(1);
          end
        end
      end
      ST_OVER: begin
        blank_d = 1'b0;
        if (frame_tick) begin
          frame_cnt_d = frame_cnt_q + FRW'(1);
          // blink_cnt tracks frame_cnt modulo the blink half-period.
          if (blink_cnt_q == '0) begin
            blink_on_d  = ~blink_on_q;
            blink_cnt_d = BLW'(OVER_BLINK_FRAMES - 1);
          end else begin
            blink_cnt_d = blink_cnt_q - BLW'(1);
          end
          if (frame_cnt_q == FRW'(OVER_HOLD_FRAMES - 1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        flash_cnt_d = '0;
        frame_cnt_d = '0;
        blank_d     = 1'b0;
      end
    endcase
  end

  // Colours are decoded from the next state so they register alongside it.
  always_comb begin
    rgb_border_d = BORDER_COLOR;
    rgb_apple_d  = 3'b000;
    rgb_snake_d  = 3'b000;
    run_d        = 1'b0;
    case (state_d)
      ST_PLAY: begin
        rgb_apple_d = APPLE_COLOR;
        rgb_snake_d = (flash_cnt_d != '0) ? FLASH_COLOR : SNAKE_COLOR;
        run_d       = 1'b1;
      end
      ST_OVER: begin
        rgb_border_d = blink_on_d ? OVER_COLOR : 3'b000;
        rgb_apple_d  = APPLE_COLOR;
        rgb_snake_d  = SNAKE_COLOR;
      end
      default: begin
        rgb_border_d = BORDER_COLOR;
      end
    endcase
  end

  assign rgb_border    = rgb_border_q;
  assign rgb_apple     = rgb_apple_q;
  assign rgb_snake     = rgb_snake_q;
  assign display_blank = blank_q;
  assign game_run      = run_q;
  assign phase         = state_q;

endmodule

// File: tb/tb_snake_color_ctrl.sv
// Self-checking bench for snake_color_ctrl: directed scenarios plus randomized
// traffic against a frame-level reference model (default and hold=1 configs).
module tb_snake_color_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1, frame_tick = 1'b0, start = 1'b0, apple_eaten = 1'b0, collision = 1'b0;
  logic [2:0] rgb_border, rgb_apple, rgb_snake, b_border, b_apple, b_snake;
  logic display_blank, game_run, b_blank, b_run;
  logic [1:0] phase, b_phase;
  logic [12:0] d1, d2;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int ph;
    int flash;
    int frames;
    bit blank;
  } mdl_t;

  mdl_t m1, m2;

  always #5 clk = ~clk;

  snake_color_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .apple_eaten(apple_eaten), .collision(collision),
    .rgb_border(rgb_border), .rgb_apple(rgb_apple), .rgb_snake(rgb_snake),
    .display_blank(display_blank), .game_run(game_run), .phase(phase)
  );

  snake_color_ctrl #(.OVER_HOLD_FRAMES(1)) dut_h1 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .apple_eaten(apple_eaten), .collision(collision),
    .rgb_border(b_border), .rgb_apple(b_apple), .rgb_snake(b_snake),
    .display_blank(b_blank), .game_run(b_run), .phase(b_phase)
  );

  assign d1 = {phase, display_blank, rgb_border, rgb_apple, rgb_snake, game_run};
  assign d2 = {b_phase, b_blank, b_border, b_apple, b_snake, b_run};

  // Frame-level game rules: what the phase, flash and OVER frame count become.
  function automatic mdl_t mstep(mdl_t m, bit r, bit st, bit ft, bit ae, bit co, int hold);
    mdl_t n = m;
    if (r) begin
      n.ph = 0; n.flash = 0; n.frames = 0; n.blank = 1'b1;
    end else if (m.ph == 0) begin
      n.blank = 1'b0;
      if (st) begin n.ph = 1; n.blank = 1'b1; end
    end else if (m.ph == 1) begin
      if (co) begin
        n.ph = 2; n.flash = 0; n.frames = 0; n.blank = 1'b0;
      end else begin
        if (ft) n.blank = 1'b0;
        if (ae) n.flash = 8;
        else if (ft && m.flash > 0) n.flash = m.flash - 1;
      end
    end else begin
      if (ft) begin
        n.frames = m.frames + 1;
        if (n.frames == hold) begin n.ph = 0; n.frames = 0; end
      end
    end
    return n;
  endfunction

  // {phase, blank, border, apple, snake, run}
  function automatic logic [12:0] exp_out(mdl_t m);
    logic [2:0] b, a, s;
    b = 3'b111; a = 3'b000; s = 3'b000;
    if (m.ph == 1) begin
      a = 3'b100; s = (m.flash > 0) ? 3'b110 : 3'b010;
    end else if (m.ph == 2) begin
      a = 3'b100; s = 3'b010;
      b = (((m.frames / 16) % 2) == 0) ? 3'b100 : 3'b000;
    end
    return {2'(m.ph), m.blank, b, a, s, (m.ph == 1)};
  endfunction

  task automatic step(input bit r, input bit st, input bit ft, input bit ae, input bit co);
    reset = r; start = st; frame_tick = ft; apple_eaten = ae; collision = co;
    @(posedge clk);
    m1 = mstep(m1, r, st, ft, ae, co, 180);
    m2 = mstep(m2, r, st, ft, ae, co, 1);
    #1;
    reset = 1'b0; start = 1'b0; frame_tick = 1'b0; apple_eaten = 1'b0; collision = 1'b0;
  endtask

  task automatic tick();
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0); step(1, 1, 1, 1, 1); step(1, 0, 1, 0, 0);
    n_cmp++;
    if (d1 !== {2'd0, 1'b1, 3'b111, 3'b000, 3'b000, 1'b0}) begin
      n_err++; $display("FAIL reset_values: got %b want %b", d1, {2'd0, 1'b1, 3'b111, 6'b0, 1'b0});
    end
    step(0, 0, 0, 0, 0);
    n_cmp++;
    if ({phase, display_blank, rgb_border} !== {2'd0, 1'b0, 3'b111}) begin
      n_err++; $display("FAIL reset_release: got ph=%0d blank=%b border=%b want 0 0 111", phase, display_blank, rgb_border);
    end
  endtask

  task automatic test_start();
    step(0, 1, 0, 0, 0);
    n_cmp++;
    if ({phase, game_run, display_blank} !== {2'd1, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL start_entry: got ph=%0d run=%b blank=%b want 1 1 1", phase, game_run, display_blank);
    end
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    n_cmp++;
    if (display_blank !== 1'b1) begin
      n_err++; $display("FAIL start_blank_hold: got %b want 1", display_blank);
    end
    step(0, 0, 1, 0, 0);
    n_cmp++;
    if ({display_blank, rgb_apple, rgb_snake, game_run} !== {1'b0, 3'b100, 3'b010, 1'b1}) begin
      n_err++; $display("FAIL start_first_tick: got blank=%b apple=%b snake=%b run=%b want 0 100 010 1",
                        display_blank, rgb_apple, rgb_snake, game_run);
    end
  endtask

  task automatic test_flash();
    step(0, 0, 0, 1, 0);
    n_cmp++;
    if (rgb_snake !== 3'b110) begin
      n_err++; $display("FAIL flash_load: got %b want 110", rgb_snake);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_cmp++;
      if (rgb_snake !== ((i < 8) ? 3'b110 : 3'b010)) begin
        n_err++; $display("FAIL flash_tick%0d: got %b want %b", i, rgb_snake, (i < 8) ? 3'b110 : 3'b010);
      end
    end
    step(0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) tick();
    step(0, 0, 1, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_cmp++;
      if (rgb_snake !== ((i < 8) ? 3'b110 : 3'b010)) begin
        n_err++; $display("FAIL flash_reload_tick%0d: got %b want %b", i, rgb_snake, (i < 8) ? 3'b110 : 3'b010);
      end
    end
  endtask

  task automatic over_run(input string tag);
    for (int k = 1; k <= 180; k++) begin
      step(0, 1, 0, 1, 1);
      step(0, 0, 1, 0, 0);
      n_cmp++;
      if (k < 180) begin
        if ({phase, rgb_border} !== {2'd2, (((k / 16) % 2) == 0) ? 3'b100 : 3'b000}) begin
          n_err++; $display("FAIL %s_tick%0d: got ph=%0d border=%b want 2 %b", tag, k, phase, rgb_border,
                            (((k / 16) % 2) == 0) ? 3'b100 : 3'b000);
        end
      end else if ({phase, rgb_border, rgb_apple, rgb_snake, game_run} !== {2'd0, 3'b111, 6'b0, 1'b0}) begin
        n_err++; $display("FAIL %s_exit: got ph=%0d border=%b apple=%b snake=%b want 0 111 000 000",
                          tag, phase, rgb_border, rgb_apple, rgb_snake);
      end
    end
  endtask

  task automatic test_collision();
    step(0, 1, 0, 0, 0); step(0, 0, 1, 0, 0); step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    n_cmp++;
    if (d1 !== {2'd2, 1'b0, 3'b100, 3'b100, 3'b010, 1'b0}) begin
      n_err++; $display("FAIL collision_entry: got %b want %b", d1, {2'd2, 1'b0, 3'b100, 3'b100, 3'b010, 1'b0});
    end
    over_run("over_blink");
  endtask

  task automatic test_over_exit();
    step(0, 1, 0, 0, 0); step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    n_cmp++;
    if ({phase, rgb_border} !== {2'd2, 3'b100}) begin
      n_err++; $display("FAIL entry_tick: got ph=%0d border=%b want 2 100", phase, rgb_border);
    end
    over_run("over_exit");
  endtask

  task automatic test_hold1();
    step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    n_cmp++;
    if ({b_phase, b_border} !== {2'd2, 3'b100}) begin
      n_err++; $display("FAIL hold1_entry: got ph=%0d border=%b want 2 100", b_phase, b_border);
    end
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    n_cmp++;
    if ({b_phase, b_border, phase} !== {2'd0, 3'b111, 2'd2}) begin
      n_err++; $display("FAIL hold1_exit: got ph=%0d border=%b main_ph=%0d want 0 111 2", b_phase, b_border, phase);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 0, 1, 0, 0); step(0, 0, 0, 1, 0);
    step(1, 0, 1, 1, 0);
    n_cmp++;
    if (d1 !== {2'd0, 1'b1, 3'b111, 6'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_mid_flash: got %b want %b", d1, {2'd0, 1'b1, 3'b111, 6'b0, 1'b0});
    end
    step(0, 1, 0, 0, 0); step(0, 0, 1, 0, 0); step(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) tick();
    step(1, 0, 1, 0, 0);
    n_cmp++;
    if (d1 !== {2'd0, 1'b1, 3'b111, 6'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_mid_over: got %b want %b", d1, {2'd0, 1'b1, 3'b111, 6'b0, 1'b0});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 399) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
      n_cmp++;
      if (d1 !== exp_out(m1)) begin
        n_err++; $display("FAIL random_main cyc%0d: got %b want %b", i, d1, exp_out(m1));
      end
      n_cmp++;
      if (d2 !== exp_out(m2)) begin
        n_err++; $display("FAIL random_hold1 cyc%0d: got %b want %b", i, d2, exp_out(m2));
      end
    end
  endtask

  initial begin
    m1 = '{ph: 0, flash: 0, frames: 0, blank: 1'b1};
    m2 = m1;
    test_reset();
    test_start();
    test_flash();
    test_collision();
    test_over_exit();
    test_hold1();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
